control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_if.sv | 59 +++++
 rtl/control_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// control_sequencer_if -- bundle of the sequencer's handshake inputs and
// datapath control outputs.
//
//   master : the sequencer side (receives run/mem_ready/ir, drives strobes)
//   slave  : the datapath/stimulus side (drives run/mem_ready/ir)
//
// Signals:
//   run, mem_ready, ir[31:0]                      -> into the sequencer
//   pc_out, zlow_out, mdr_out, pc_in, inc_pc,
//   mar_in, mdr_in, read, ir_in, y_in, z_in       <- one-bit datapath strobes
//   r_out, r_in [NUM_REGS-1:0]                    <- one-hot register enables
//   alu_select[4:0], halted, illegal, state[3:0]  <- ALU op and status
//   zhigh_out                                     <- only with CTRL_ZHI_EN defined
interface control_sequencer_if #(
    parameter int unsigned NUM_REGS = 16
);
    logic                run;
    logic                mem_ready;
    logic [31:0]         ir;

    logic                pc_out;
    logic                zlow_out;
    logic                mdr_out;
    logic                pc_in;
    logic                inc_pc;
    logic                mar_in;
    logic                mdr_in;
    logic                read;
    logic                ir_in;
    logic                y_in;
    logic                z_in;
    logic [NUM_REGS-1:0] r_out;
    logic [NUM_REGS-1:0] r_in;
    logic [4:0]          alu_select;
    logic                halted;
    logic                illegal;
    logic [3:0]          state;
`ifdef CTRL_ZHI_EN
    logic                zhigh_out;
`endif

    modport master (
        input  run, mem_ready, ir,
        output pc_out, zlow_out, mdr_out, pc_in, inc_pc, mar_in, mdr_in, read, ir_in,
               y_in, z_in, r_out, r_in, alu_select, halted, illegal, state
`ifdef CTRL_ZHI_EN
        , output zhigh_out
`endif
    );

    modport slave (
        output run, mem_ready, ir,
        input  pc_out, zlow_out, mdr_out, pc_in, inc_pc, mar_in, mdr_in, read, ir_in,
               y_in, z_in, r_out, r_in, alu_select, halted, illegal, state
`ifdef CTRL_ZHI_EN
        , input zhigh_out
`endif
    );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer -- hardwired control unit for a single-bus CPU datapath.
// Sequences fetch (T0..T2, with T1W memory wait states) and an ALU execute
// (T3..T5) per instruction, and parks in HALT on the halt opcode.
//
// Ports:
//   clk    : sole clock, rising edge
//   reset  : synchronous, active-high; returns to IDLE from any state
//   bus    : control_sequencer_if.master (run/mem_ready/ir in, strobes out)
//
// Optional feature: define CTRL_ZHI_EN to add state T6 and the zhigh_out
// strobe, writing the high half of Z into R[(Ra+1) mod NUM_REGS] after mul/div.
//
// All outputs are Moore functions of the state register and ir. State-only
// strobes are registered from the next state; ir-dependent fields are decoded
// from the current state and ir.
module control_sequencer #(
    parameter int unsigned NUM_REGS = 16,
    parameter logic [4:0]  HALT_OP  = 5'b11011
) (
    input logic clk,
    input logic reset,
    control_sequencer_if.master bus
);

    // Encoding follows the listing order; IDLE must be 0.
    typedef enum logic [3:0] {
        StIdle = 4'd0,
        StT0   = 4'd1,
        StT1   = 4'd2,
        StT1W  = 4'd3,
        StT2   = 4'd4,
        StT3   = 4'd5,
        StT4   = 4'd6,
        StT5   = 4'd7,
        StHalt = 4'd8
`ifdef CTRL_ZHI_EN
        , StT6 = 4'd9
`endif
    } state_e;

    typedef struct packed {
        logic pc_out;
        logic zlow_out;
        logic mdr_out;
        logic pc_in;
        logic inc_pc;
        logic mar_in;
        logic mdr_in;
        logic read;
        logic ir_in;
        logic z_in;
        logic halted;
`ifdef CTRL_ZHI_EN
        logic zhigh_out;
`endif
    } strobe_t;

    localparam logic [4:0] OpMul = 5'b01110;
    localparam logic [4:0] OpDiv = 5'b01111;

    state_e  state_q, state_d;
    strobe_t strobe_q;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       unused_ir;

    assign opcode    = bus.ir[31:27];
    assign ra        = bus.ir[26:23];
    assign rb        = bus.ir[22:19];
    assign rc        = bus.ir[18:15];
    assign unused_ir = ^bus.ir[14:0];

    // Shifting past the top bit yields zero, which gives the "no bit for an
    // out-of-range index" behaviour for free.
    function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
        return {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic out_of_range(input logic [3:0] idx);
        return 32'(idx) >= NUM_REGS;
    endfunction

    function automatic strobe_t strobes_for(input state_e s);
        strobe_t st;
        st = '0;
        case (s)
            StT0: begin
                st.pc_out = 1'b1;
                st.mar_in = 1'b1;
                st.inc_pc = 1'b1;
                st.z_in   = 1'b1;
            end
            StT1: begin
                st.zlow_out = 1'b1;
                st.pc_in    = 1'b1;
                st.read     = 1'b1;
                st.mdr_in   = 1'b1;
            end
            StT1W: begin
                st.read   = 1'b1;
                st.mdr_in = 1'b1;
            end
            StT2: begin
                st.mdr_out = 1'b1;
                st.ir_in   = 1'b1;
            end
            StT4:   st.z_in     = 1'b1;
            StT5:   st.zlow_out = 1'b1;
            StHalt: st.halted   = 1'b1;
`ifdef CTRL_ZHI_EN
            StT6:   st.zhigh_out = 1'b1;
`endif
            default: ;
        endcase
        return st;
    endfunction

    // End-of-instruction rule: run is only consulted here and in IDLE.
    function automatic state_e after_instr(input logic run);
        return run ? StT0 : StIdle;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (bus.run) state_d = StT0;
            StT0:   state_d = StT1;
            StT1:   state_d = bus.mem_ready ? StT2 : StT1W;
            StT1W:  state_d = bus.mem_ready ? StT2 : StT1W;
            StT2:   state_d = StT3;
            StT3:   state_d = (opcode == HALT_OP) ? StHalt : StT4;
            StT4:   state_d = StT5;
`ifdef CTRL_ZHI_EN
            StT5: begin
                if (opcode == OpMul || opcode == OpDiv) state_d = StT6;
                else state_d = after_instr(bus.run);
            end
            StT6:   state_d = after_instr(bus.run);
`else
            StT5:   state_d = after_instr(bus.run);
`endif
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            strobe_q <= '0;
        end else begin
            state_q  <= state_d;
            strobe_q <= strobes_for(state_d);
        end
    end

`ifdef CTRL_ZHI_EN
    logic [3:0] ra_wrap;
    assign ra_wrap = 4'((32'(ra) + 32'd1) % NUM_REGS);
`endif

    // Register-index and ALU fields depend on ir, which is loaded during T2,
    // so they are decoded from the current state rather than registered.
    always_comb begin
        bus.r_out      = '0;
        bus.r_in       = '0;
        bus.alu_select = 5'd0;
        bus.illegal    = 1'b0;
        bus.y_in       = 1'b0;
        case (state_q)
            StT3: begin
                if (opcode != HALT_OP) begin
                    bus.r_out   = onehot(rb);
                    bus.y_in    = 1'b1;
                    bus.illegal = out_of_range(rb);
                end
            end
            StT4: begin
                bus.r_out      = onehot(rc);
                bus.alu_select = opcode;
                bus.illegal    = out_of_range(rc);
            end
            StT5: begin
                bus.r_in    = onehot(ra);
                bus.illegal = out_of_range(ra);
            end
`ifdef CTRL_ZHI_EN
            StT6: bus.r_in = onehot(ra_wrap);
`endif
            default: ;
        endcase
    end

    assign bus.pc_out   = strobe_q.pc_out;
    assign bus.zlow_out = strobe_q.zlow_out;
    assign bus.mdr_out  = strobe_q.mdr_out;
    assign bus.pc_in    = strobe_q.pc_in;
    assign bus.inc_pc   = strobe_q.inc_pc;
    assign bus.mar_in   = strobe_q.mar_in;
    assign bus.mdr_in   = strobe_q.mdr_in;
    assign bus.read     = strobe_q.read;
    assign bus.ir_in    = strobe_q.ir_in;
    assign bus.z_in     = strobe_q.z_in;
    assign bus.halted   = strobe_q.halted;
    assign bus.state    = state_q;
`ifdef CTRL_ZHI_EN
    assign bus.zhigh_out = strobe_q.zhigh_out;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer -- directed bench for control_sequencer. Two instances
// (NUM_REGS=16 and NUM_REGS=8) share the same stimulus. Each cycle the bench
// names the step the instruction should be in; a model derives every output
// from that step and ir, and one compare process checks both DUTs at negedge.
// State codes expected: listing order IDLE=0, T0..T5=1..7 (T1W=3), HALT=8, T6=9.
module tb_control_sequencer;

    typedef enum int {SIdle, ST0, ST1, ST1W, ST2, ST3, ST4, ST5, SHalt, ST6} step_e;

    typedef struct packed {
        logic        pc_out, zlow_out, mdr_out, pc_in, inc_pc, mar_in, mdr_in, read;
        logic        ir_in, y_in, z_in, halted, illegal, zhigh;
        logic [4:0]  alu;
        logic [3:0]  state;
        logic [15:0] r_out, r_in;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset_v = 1'b1;
    logic        run_v = 1'b0;
    logic        mr_v = 1'b0;
    logic [31:0] ir_v = 32'd0;
    step_e       exp_step = SIdle;
    logic        exp_valid = 1'b1;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    control_sequencer_if #(.NUM_REGS(16)) bus16 ();
    control_sequencer_if #(.NUM_REGS(8))  bus8 ();

    assign bus16.run = run_v;
    assign bus16.mem_ready = mr_v;
    assign bus16.ir = ir_v;
    assign bus8.run = run_v;
    assign bus8.mem_ready = mr_v;
    assign bus8.ir = ir_v;

    control_sequencer #(.NUM_REGS(16)) dut16 (.clk(clk), .reset(reset_v), .bus(bus16));
    control_sequencer #(.NUM_REGS(8))  dut8  (.clk(clk), .reset(reset_v), .bus(bus8));

    obs_t act16, act8;

    always_comb begin
        act16 = '0;
        act16.pc_out = bus16.pc_out;     act16.zlow_out = bus16.zlow_out;
        act16.mdr_out = bus16.mdr_out;   act16.pc_in = bus16.pc_in;
        act16.inc_pc = bus16.inc_pc;     act16.mar_in = bus16.mar_in;
        act16.mdr_in = bus16.mdr_in;     act16.read = bus16.read;
        act16.ir_in = bus16.ir_in;       act16.y_in = bus16.y_in;
        act16.z_in = bus16.z_in;         act16.halted = bus16.halted;
        act16.illegal = bus16.illegal;   act16.alu = bus16.alu_select;
        act16.state = bus16.state;       act16.r_out = bus16.r_out;
        act16.r_in = bus16.r_in;
`ifdef CTRL_ZHI_EN
        act16.zhigh = bus16.zhigh_out;
`endif
    end

    always_comb begin
        act8 = '0;
        act8.pc_out = bus8.pc_out;       act8.zlow_out = bus8.zlow_out;
        act8.mdr_out = bus8.mdr_out;     act8.pc_in = bus8.pc_in;
        act8.inc_pc = bus8.inc_pc;       act8.mar_in = bus8.mar_in;
        act8.mdr_in = bus8.mdr_in;       act8.read = bus8.read;
        act8.ir_in = bus8.ir_in;         act8.y_in = bus8.y_in;
        act8.z_in = bus8.z_in;           act8.halted = bus8.halted;
        act8.illegal = bus8.illegal;     act8.alu = bus8.alu_select;
        act8.state = bus8.state;         act8.r_out = {8'd0, bus8.r_out};
        act8.r_in = {8'd0, bus8.r_in};
`ifdef CTRL_ZHI_EN
        act8.zhigh = bus8.zhigh_out;
`endif
    end

    // What the outputs must be in a given step of an instruction.
    function automatic obs_t model(input step_e s, input logic [31:0] v, input int n);
        obs_t o;
        int op, ra, rb, rc;
        o  = '0;
        op = int'(v[31:27]);
        ra = int'(v[26:23]);
        rb = int'(v[22:19]);
        rc = int'(v[18:15]);
        case (s)
            SIdle: ;
            ST0: begin
                o.state = 4'd1; o.pc_out = 1'b1; o.mar_in = 1'b1;
                o.inc_pc = 1'b1; o.z_in = 1'b1;
            end
            ST1: begin
                o.state = 4'd2; o.zlow_out = 1'b1; o.pc_in = 1'b1;
                o.read = 1'b1; o.mdr_in = 1'b1;
            end
            ST1W: begin
                o.state = 4'd3; o.read = 1'b1; o.mdr_in = 1'b1;
            end
            ST2: begin
                o.state = 4'd4; o.mdr_out = 1'b1; o.ir_in = 1'b1;
            end
            ST3: begin
                o.state = 4'd5;
                if (op != 27) begin
                    o.y_in = 1'b1;
                    if (rb < n) o.r_out[rb] = 1'b1;
                    else o.illegal = 1'b1;
                end
            end
            ST4: begin
                o.state = 4'd6; o.z_in = 1'b1; o.alu = 5'(op);
                if (rc < n) o.r_out[rc] = 1'b1;
                else o.illegal = 1'b1;
            end
            ST5: begin
                o.state = 4'd7; o.zlow_out = 1'b1;
                if (ra < n) o.r_in[ra] = 1'b1;
                else o.illegal = 1'b1;
            end
            SHalt: begin
                o.state = 4'd8; o.halted = 1'b1;
            end
            ST6: begin
                o.state = 4'd9; o.zhigh = 1'b1;
                o.r_in[(ra + 1) % n] = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            obs_t e16, e8;
            e16 = model(exp_step, ir_v, 16);
            e8  = model(exp_step, ir_v, 8);
            n_cmp++;
            if (act16 !== e16) begin
                n_bad++;
                $display("FAIL step16 %s: got %h want %h", exp_step.name(), act16, e16);
            end
            n_cmp++;
            if (act8 !== e8) begin
                n_bad++;
                $display("FAIL step8 %s: got %h want %h", exp_step.name(), act8, e8);
            end
        end
    end

    // Instruction length: from the T0 cycle (inc_pc) to the T5 cycle (zlow_out without pc_in).
    int cyc_cnt = 0;
    int t0_at = 0;
    int instr_len = 0;
    always @(negedge clk) begin
        cyc_cnt++;
        if (bus16.inc_pc) t0_at = cyc_cnt;
        if (bus16.zlow_out && !bus16.pc_in) instr_len = cyc_cnt - t0_at + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One clock: s is the step the DUT should show this cycle; rs/r/m/v are
    // the inputs it sees at the next rising edge.
    task automatic cyc(input step_e s, input logic rs, input logic r, input logic m,
                       input logic [31:0] v);
        @(posedge clk);
        #1;
        reset_v  = rs;
        run_v    = r;
        mr_v     = m;
        ir_v     = v;
        exp_step = s;
        @(negedge clk);
        #1;
    endtask

    localparam logic [31:0] IrA = 32'h4A92_0000;
    localparam logic [31:0] IrB = {5'b00001, 4'd1, 4'd9, 4'd3, 15'd0};
    localparam logic [31:0] IrH = {5'b11011, 27'd0};
    localparam logic [31:0] IrW = {5'b01110, 4'd15, 4'd1, 4'd2, 15'd0};

    initial begin
        // Reset
        cyc(SIdle, 1'b1, 1'b0, 1'b0, 32'd0);
        cyc(SIdle, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("rst_state", 32'(bus16.state), 32'd0);
        chk("rst_halted", 32'(bus16.halted), 32'd0);

        // Plain ALU instruction, no wait states, run dropped at T5
        cyc(SIdle, 1'b0, 1'b1, 1'b0, IrA);
        cyc(ST0,   1'b0, 1'b1, 1'b0, IrA);
        cyc(ST1,   1'b0, 1'b1, 1'b1, IrA);
        cyc(ST2,   1'b0, 1'b1, 1'b0, IrA);
        cyc(ST3,   1'b0, 1'b1, 1'b0, IrA);
        chk("a_t3_rout", 32'(bus16.r_out), 32'h0004);
        cyc(ST4,   1'b0, 1'b1, 1'b0, IrA);
        chk("a_t4_rout", 32'(bus16.r_out), 32'h0010);
        chk("a_t4_alu", 32'(bus16.alu_select), 32'(5'b01001));
        cyc(ST5,   1'b0, 1'b0, 1'b0, IrA);
        chk("a_t5_rin", 32'(bus16.r_in), 32'h0020);
        chk("a_len", 32'(instr_len), 32'd6);

        // Three T1W wait states, then run=1 at T5 continues straight to T0
        cyc(SIdle, 1'b0, 1'b1, 1'b0, IrA);
        cyc(ST0,   1'b0, 1'b1, 1'b0, IrA);
        cyc(ST1,   1'b0, 1'b1, 1'b0, IrA);
        cyc(ST1W,  1'b0, 1'b1, 1'b0, IrA);
        chk("b_t1w_pcin", 32'(bus16.pc_in), 32'd0);
        chk("b_t1w_read", 32'({bus16.read, bus16.mdr_in}), 32'd3);
        cyc(ST1W,  1'b0, 1'b1, 1'b0, IrA);
        cyc(ST1W,  1'b0, 1'b1, 1'b1, IrA);
        cyc(ST2,   1'b0, 1'b1, 1'b0, IrA);
        cyc(ST3,   1'b0, 1'b1, 1'b0, IrA);
        cyc(ST4,   1'b0, 1'b1, 1'b0, IrA);
        cyc(ST5,   1'b0, 1'b1, 1'b0, IrA);
        chk("b_len", 32'(instr_len), 32'd9);

        // run=0 mid-instruction; Rb=9 is out of range for the 8-register build
        cyc(ST0,   1'b0, 1'b0, 1'b0, IrB);
        cyc(ST1,   1'b0, 1'b0, 1'b1, IrB);
        cyc(ST2,   1'b0, 1'b0, 1'b0, IrB);
        cyc(ST3,   1'b0, 1'b0, 1'b0, IrB);
        chk("c_t3_illegal8", 32'(bus8.illegal), 32'd1);
        chk("c_t3_rout8", 32'(bus8.r_out), 32'd0);
        chk("c_t3_yin8", 32'(bus8.y_in), 32'd1);
        chk("c_t3_rout16", 32'(bus16.r_out), 32'h0200);
        cyc(ST4,   1'b0, 1'b0, 1'b0, IrB);
        cyc(ST5,   1'b0, 1'b0, 1'b0, IrB);
        chk("c_len", 32'(instr_len), 32'd6);
        cyc(SIdle, 1'b0, 1'b0, 1'b0, IrB);

        // Halt opcode: parks in HALT regardless of run/mem_ready until reset
        cyc(SIdle, 1'b0, 1'b1, 1'b0, IrH);
        cyc(ST0,   1'b0, 1'b1, 1'b0, IrH);
        cyc(ST1,   1'b0, 1'b1, 1'b1, IrH);
        cyc(ST2,   1'b0, 1'b1, 1'b1, IrH);
        cyc(ST3,   1'b0, 1'b1, 1'b1, IrH);
        chk("d_t3_yin", 32'(bus16.y_in), 32'd0);
        for (int i = 0; i < 3; i++) cyc(SHalt, 1'b0, 1'b1, 1'b1, IrH);
        chk("d_halted", 32'(bus16.halted), 32'd1);
        cyc(SHalt, 1'b1, 1'b1, 1'b1, IrH);
        cyc(SIdle, 1'b0, 1'b0, 1'b0, IrH);
        chk("d_after_rst", 32'({bus16.halted, bus16.state}), 32'd0);

        // Reset during a memory wait
        cyc(SIdle, 1'b0, 1'b1, 1'b0, IrA);
        cyc(ST0,   1'b0, 1'b1, 1'b0, IrA);
        cyc(ST1,   1'b0, 1'b1, 1'b0, IrA);
        cyc(ST1W,  1'b1, 1'b1, 1'b0, IrA);
        cyc(SIdle, 1'b0, 1'b0, 1'b0, IrA);
        chk("e_state", 32'(bus16.state), 32'd0);
        chk("e_read", 32'({bus16.read, bus16.mdr_in}), 32'd0);

        // mul with Ra=15: wraps to R0 for the high half when enabled
        cyc(SIdle, 1'b0, 1'b1, 1'b0, IrW);
        cyc(ST0,   1'b0, 1'b1, 1'b0, IrW);
        cyc(ST1,   1'b0, 1'b1, 1'b1, IrW);
        cyc(ST2,   1'b0, 1'b1, 1'b0, IrW);
        cyc(ST3,   1'b0, 1'b1, 1'b0, IrW);
        cyc(ST4,   1'b0, 1'b1, 1'b0, IrW);
        cyc(ST5,   1'b0, 1'b0, 1'b0, IrW);
        chk("f_t5_rin", 32'(bus16.r_in), 32'h8000);
`ifdef CTRL_ZHI_EN
        cyc(ST6,   1'b0, 1'b0, 1'b0, IrW);
        chk("f_t6_zhigh", 32'(bus16.zhigh_out), 32'd1);
        chk("f_t6_rin", 32'(bus16.r_in), 32'h0001);
`endif
        cyc(SIdle, 1'b0, 1'b0, 1'b0, IrW);
        cyc(SIdle, 1'b0, 1'b0, 1'b0, IrW);

        exp_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
